// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with valid/ready handshake and a MUL/DIV latency
// sequencer. Define ALU_CTRL_DIV_EN to decode DIV as a multi-cycle op (otherwise DIV is illegal).
module alu_ctrl_seq #(
  parameter int FUNC_W     = 6,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUop,
  input  logic              addi,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUctrlop,
  output logic              multi,
  output logic              illegal
);

  if (FUNC_W < 6 || CTRL_W < 4 || MUL_CYCLES < 1 || MUL_CYCLES > 255 ||
      DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_param
    $error("alu_ctrl_seq: parameter out of range");
  end

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] OP_ILL  = CTRL_W'(4'b1111);
  localparam logic [7:0]        MUL_LD  = 8'(MUL_CYCLES - 1);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CTRL_W-1:0] OP_DIV  = CTRL_W'(4'b1001);
  localparam logic [7:0]        DIV_LD  = 8'(DIV_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] op;
    logic              mul;
    logic              ill;
    logic [7:0]        ld;
  } dec_t;

  // Multi-cycle ops carry their wait-counter load value; single-cycle ops load 0.
  function automatic dec_t decode(input logic [1:0] aluop, input logic add_i,
                                  input logic [FUNC_W-1:0] f);
    dec_t d;
    d.op  = OP_ILL;
    d.mul = 1'b0;
    d.ill = 1'b1;
    d.ld  = 8'd0;
    case (aluop)
      2'b00: begin d.op = OP_ADD; d.ill = 1'b0; end
      2'b01: begin d.op = OP_SUB; d.ill = 1'b0; end
      2'b10: begin
        if (add_i) begin
          d.op  = OP_ADD;
          d.ill = 1'b0;
        end else if (f[5:4] == 2'b01 && f[3:0] == 4'b1000) begin
          d.op  = OP_MUL;
          d.mul = 1'b1;
          d.ill = 1'b0;
          d.ld  = MUL_LD;
        end else if (f[5:4] == 2'b01 && f[3:0] == 4'b1010) begin
`ifdef ALU_CTRL_DIV_EN
          d.op  = OP_DIV;
          d.mul = 1'b1;
          d.ill = 1'b0;
          d.ld  = DIV_LD;
`endif
        end else begin
          case (f[3:0])
            4'b0000: begin d.op = OP_ADD; d.ill = 1'b0; end
            4'b0010: begin d.op = OP_SUB; d.ill = 1'b0; end
            4'b0100: begin d.op = OP_AND; d.ill = 1'b0; end
            4'b0101: begin d.op = OP_OR;  d.ill = 1'b0; end
            4'b0111: begin d.op = OP_NOR; d.ill = 1'b0; end
            4'b1010: begin d.op = OP_SLT; d.ill = 1'b0; end
            default: ;
          endcase
        end
      end
      default: begin
        case (f[3:0])
          4'b0010: begin d.op = OP_SUB; d.ill = 1'b0; end
          4'b1010: begin d.op = OP_SLT; d.ill = 1'b0; end
          default: ;
        endcase
      end
    endcase
    return d;
  endfunction

  state_t            state, state_nxt;
  dec_t              dec;
  logic              accept;
  logic [7:0]        cnt;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              multi_p1;
  logic              illegal_p1;

  assign dec    = decode(ALUop, addi, func);
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = dec.mul ? S_WAIT : S_HOLD;
      S_WAIT: if (cnt == 8'd0) state_nxt = S_HOLD;
      S_HOLD: if (out_ready) state_nxt = accept ? (dec.mul ? S_WAIT : S_HOLD) : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // in_ready is gated by reset_n so nothing is accepted while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = reset_n;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready & reset_n;
      end
      default: ;
    endcase
  end

  // Stage p1: decoded op captured on accept, wait counter runs down in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 8'd0;
      ctrl_p1    <= '0;
      multi_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (accept) begin
      cnt        <= dec.ld;
      ctrl_p1    <= dec.op;
      multi_p1   <= dec.mul;
      illegal_p1 <= dec.ill;
    end else if (state == S_WAIT && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign ALUctrlop = ctrl_p1;
  assign multi     = multi_p1;
  assign illegal   = illegal_p1;

endmodule
